// File: rtl/f32_divider.sv
// IEEE-754 binary32 divider: 25-cycle restoring mantissa division, truncating rounding,
// denormals flushed to zero, fixed 27-cycle latency for every operand class.
module f32_divider (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        start,
   output logic [31:0] r,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic        underflow,
   output logic        div_by_zero
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DIVIDE = 2'd1;
   localparam logic [1:0] S_NORM   = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   logic [1:0]        state;
   logic [4:0]        cnt;
   logic [24:0]       rem;
   logic [23:0]       dvs;
   logic [24:0]       q;
   logic signed [9:0] e;
   logic              sign;
   logic [22:0]       frac;
   logic              special;
   logic [31:0]       spec_r;
   logic              spec_dbz;

   logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic sp_hit, sp_dbz, s_in;
   logic [31:0] sp_r;
   logic rem_ge;
   logic [24:0] rem_sub, rem_next;
   logic [31:0] res_r;
   logic res_ov, res_un, res_dbz;

   assign a_zero = (a[30:23] == 8'h00);
   assign b_zero = (b[30:23] == 8'h00);
   assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
   assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
   assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
   assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
   assign s_in   = a[31] ^ b[31];

   // Operand classification at accept; the winning special result bypasses the arithmetic.
   always_comb begin
      sp_hit = 1'b1;
      sp_r   = 32'h0000_0000;
      sp_dbz = 1'b0;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         sp_r = 32'h7FC0_0000;
      end else if (a_inf) begin
         sp_r = {s_in, 8'hFF, 23'h0};
      end else if (b_inf || a_zero) begin
         sp_r = {s_in, 31'h0};
      end else if (b_zero) begin
         sp_r   = {s_in, 8'hFF, 23'h0};
         sp_dbz = 1'b1;
      end else begin
         sp_hit = 1'b0;
      end
   end

   // One restoring-division step; the remainder after subtraction is below the divisor so the shift is lossless.
   always_comb begin
      rem_ge   = (rem >= {1'b0, dvs});
      rem_sub  = rem_ge ? (rem - {1'b0, dvs}) : rem;
      rem_next = {rem_sub[23:0], 1'b0};
   end

   // Final result selection with range checks.
   always_comb begin
      res_r   = 32'h0000_0000;
      res_ov  = 1'b0;
      res_un  = 1'b0;
      res_dbz = 1'b0;
      if (special) begin
         res_r   = spec_r;
         res_dbz = spec_dbz;
      end else if (e >= 10'sd255) begin
         res_r  = {sign, 8'hFF, 23'h0};
         res_ov = 1'b1;
      end else if (e <= 10'sd0) begin
         res_r  = {sign, 31'h0};
         res_un = 1'b1;
      end else begin
         res_r = {sign, e[7:0], frac};
      end
   end

   // Control FSM and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= 5'd0;
         rem         <= 25'd0;
         dvs         <= 24'd0;
         q           <= 25'd0;
         e           <= 10'sd0;
         sign        <= 1'b0;
         frac        <= 23'd0;
         special     <= 1'b0;
         spec_r      <= 32'h0000_0000;
         spec_dbz    <= 1'b0;
         r           <= 32'h0000_0000;
         busy        <= 1'b0;
         done        <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_DIVIDE;
                  busy        <= 1'b1;
                  cnt         <= 5'd0;
                  rem         <= {2'b01, a[22:0]};
                  dvs         <= {1'b1, b[22:0]};
                  q           <= 25'd0;
                  e           <= $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
                  sign        <= s_in;
                  special     <= sp_hit;
                  spec_r      <= sp_r;
                  spec_dbz    <= sp_dbz;
                  r           <= 32'h0000_0000;
                  overflow    <= 1'b0;
                  underflow   <= 1'b0;
                  div_by_zero <= 1'b0;
               end
            end
            S_DIVIDE: begin
               rem <= rem_next;
               q   <= {q[23:0], rem_ge};
               cnt <= cnt + 5'd1;
               if (cnt == 5'd24) begin
                  state <= S_NORM;
               end
            end
            S_NORM: begin
               if (q[24]) begin
                  frac <= q[23:1];
               end else begin
                  frac <= q[22:0];
                  e    <= e - 10'sd1;
               end
               state <= S_FINISH;
            end
            S_FINISH: begin
               r           <= res_r;
               overflow    <= res_ov;
               underflow   <= res_un;
               div_by_zero <= res_dbz;
               done        <= 1'b1;
               busy        <= 1'b0;
               state       <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_f32_divider.sv
// Scoreboard bench for f32_divider: directed vectors queue expectations, a monitor checks each DONE.
module tb_f32_divider;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a = 32'h0;
   logic [31:0] b = 32'h0;
   logic [31:0] r;
   logic        busy, done, overflow, underflow, div_by_zero;

   f32_divider dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .start(start),
      .r(r), .busy(busy), .done(done), .overflow(overflow),
      .underflow(underflow), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] r;
      logic [2:0]  flags;
      int          acc;
      string       name;
   } exp_t;

   exp_t sb[$];
   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // Monitor: pops and compares one expectation per DONE pulse.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 64'd1, 64'd0);
            end else begin
               x = sb.pop_front();
               chk($sformatf("%s_r", x.name), {32'h0, r}, {32'h0, x.r});
               chk($sformatf("%s_flags", x.name), {61'h0, overflow, underflow, div_by_zero}, {61'h0, x.flags});
               chk($sformatf("%s_latency", x.name), 64'(cyc), 64'(x.acc + 27));
               chk($sformatf("%s_busy_low", x.name), {63'h0, busy}, 64'd0);
            end
         end
      end
   end

   task automatic push(input logic [31:0] er, input logic [2:0] ef, input string nm, input int acc);
      exp_t x;
      x.r = er; x.flags = ef; x.name = nm; x.acc = acc;
      sb.push_back(x);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("idle_timeout", 64'd1, 64'd0);
   endtask

   // flags order: {overflow, underflow, div_by_zero}
   task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] er,
                        input logic [2:0] ef, input string nm);
      wait_idle();
      a = va; b = vb; start = 1'b1;
      push(er, ef, nm, cyc + 1);
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("%s_busy_high", nm), {63'h0, busy}, 64'd1);
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || busy !== 1'b0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("drain_timeout", 64'd1, 64'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev;
      int acc;
      logic [31:0] ba [3];
      logic [31:0] bb [3];
      logic [31:0] br [3];
      repeat (2) @(negedge clk);
      chk("reset_outputs", {27'h0, r, busy, done, overflow, underflow, div_by_zero}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, "six_by_two");
      issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000, "one_third");
      issue(32'hBF800000, 32'h00000000, 32'hFF800000, 3'b001, "neg_by_zero");
      issue(32'h00000000, 32'h00000000, 32'h7FC00000, 3'b000, "zero_by_zero");
      issue(32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b100, "overflow");
      issue(32'h00800000, 32'h40000000, 32'h00000000, 3'b010, "underflow");
      issue(32'h7F800000, 32'h40000000, 32'h7F800000, 3'b000, "inf_by_fin");
      issue(32'h3F800000, 32'hFF800000, 32'h80000000, 3'b000, "fin_by_neginf");
      issue(32'h80000000, 32'h3F800000, 32'h80000000, 3'b000, "negzero_by_one");
      issue(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b000, "nan_in");
      issue(32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b000, "inf_by_inf");
      issue(32'h40400000, 32'h3F800000, 32'h40400000, 3'b000, "three_by_one");
      issue(32'hC1200000, 32'h40A00000, 32'hC0000000, 3'b000, "m10_by_5");
      issue(32'h00400000, 32'h3F800000, 32'h00000000, 3'b000, "denorm_num");
      issue(32'h3F800000, 32'h00400000, 32'h7F800000, 3'b001, "denorm_den");
      drain();
      repeat (5) @(negedge clk);
      chk("hold_after_done", {28'h0, r, overflow, underflow, div_by_zero}, {28'h0, 32'h7F800000, 3'b001});

      // START re-pulsed mid-operation must not disturb the result in flight
      issue(32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, "busy_ignore");
      repeat (9) @(negedge clk);
      a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();

      // Reset mid-divide: no DONE, outputs cleared at once
      wait_idle();
      a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("reset_mid_op", {27'h0, r, busy, done, overflow, underflow, div_by_zero}, 64'd0);
      a = 32'hC1200000; b = 32'h40A00000; start = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      push(32'hC0000000, 3'b000, "start_thru_reset", cyc + 1);
      @(negedge clk);
      start = 1'b0;
      drain();

      // Back-to-back with START held high
      ba[0] = 32'h40C00000; bb[0] = 32'h40000000; br[0] = 32'h40400000;
      ba[1] = 32'hC1200000; bb[1] = 32'h40A00000; br[1] = 32'hC0000000;
      ba[2] = 32'h3F800000; bb[2] = 32'h40400000; br[2] = 32'h3EAAAAAA;
      prev = 0;
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_idle();
         a = ba[i]; b = bb[i];
         acc = cyc + 1;
         push(br[i], 3'b000, $sformatf("b2b%0d", i), acc);
         if (i > 0) chk($sformatf("b2b_period%0d", i), 64'(acc - prev), 64'd28);
         prev = acc;
         @(negedge clk);
         if (i == 2) start = 1'b0;
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/f32_divider.md
F32_DIVIDER -- requirements
Module: f32_divider

Interface
REQ-001 SHALL have no parameters; operand and result format fixed at IEEE-754 binary32.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-004 A  input  32  dividend (binary32), sampled on the edge that accepts START.
REQ-005 B  input  32  divisor (binary32), sampled on the same edge.
REQ-006 START  input  1  request; accepted only while BUSY=0.
REQ-007 R  output  32  quotient A/B (binary32).
REQ-008 BUSY  output  1  high from accept edge until DONE edge.
REQ-009 DONE  output  1  one-cycle pulse, R and flags valid.
REQ-010 OVERFLOW  output  1  result exponent >= 255, R forced to signed infinity.
REQ-011 UNDERFLOW  output  1  result exponent <= 0, R forced to signed zero.
REQ-012 DIV_BY_ZERO  output  1  finite nonzero A divided by zero.

Function
REQ-013 SHALL implement FSM IDLE -> DIVIDE (25 cycles) -> NORM (1 cycle) -> FINISH (1 cycle) -> IDLE.
REQ-014 IDLE with START=1 at edge k: SHALL latch A and B, set BUSY=1, enter DIVIDE, clear R and all flags.
REQ-015 START while BUSY=1 SHALL be ignored, with no effect on the operation in flight.
REQ-016 DONE SHALL be high for exactly the cycle following edge k+27; BUSY SHALL drop on that same edge.
REQ-017 Latency SHALL be 27 cycles for every operand class, special cases included.
REQ-018 A START in IDLE on the cycle DONE is high SHALL be accepted, so back-to-back throughput is one result per 28 cycles.
REQ-019 R and flags SHALL hold their values after DONE until the next accepted START.
REQ-020 Sign SHALL be A[31] XOR B[31] for all results except NaN.
REQ-021 Exponent SHALL be computed as e = ea - eb + 127 in a 10-bit signed register.
REQ-022 Mantissa SHALL use restoring division, one quotient bit per DIVIDE cycle, MSB first:
  - remainder initialised to {1,ma} (25b); divisor {1,mb};
  - each cycle: if rem >= div, qbit=1 and rem -= div, else qbit=0; then rem <<= 1;
  - 25-bit quotient q, bit 24 is the integer bit.
REQ-023 NORM SHALL select the fraction as follows:
  - if q[24]=1: fraction = q[23:1], e unchanged;
  - else: fraction = q[22:0], e = e-1.
REQ-024 Rounding SHALL be truncation (round toward zero); no guard, round or sticky bits.
REQ-025 Range checks after NORM SHALL be:
  - e >= 255: R = {s,8'hFF,23'h0}, OVERFLOW=1;
  - e <= 0: R = {s,31'h0}, UNDERFLOW=1.
REQ-026 Denormal inputs (exp=0) SHALL be treated as zero.
REQ-027 Special cases, decided at accept and applied at FINISH, SHALL override the arithmetic path:
  - any NaN, 0/0 or inf/inf -> 32'h7FC00000, no flags;
  - inf/finite -> signed inf;
  - finite/inf -> signed zero;
  - 0/nonzero -> signed zero;
  - nonzero finite/0 -> signed inf, DIV_BY_ZERO=1.
REQ-028 At most one of OVERFLOW, UNDERFLOW or DIV_BY_ZERO SHALL be set per result.

Reset
REQ-029 RST_N low SHALL immediately force state=IDLE and R=0, BUSY=0, DONE=0, OVERFLOW=0, UNDERFLOW=0, DIV_BY_ZERO=0, with internal registers cleared.
REQ-030 Reset during DIVIDE or NORM SHALL abandon the operation with no DONE pulse; the first START after release SHALL be handled normally.
REQ-031 START held high during reset SHALL be accepted on the first rising edge after RST_N deasserts.

Verification
REQ-032 A=40C00000 (6.0), B=40000000 (2.0), START pulse -> DONE exactly 27 cycles later, R=40400000, all flags 0.
REQ-033 A=3F800000, B=40400000 (1/3) -> R=3EAAAAAA (truncated, not 3EAAAAAB).
REQ-034 A=BF800000, B=00000000 -> R=FF800000, DIV_BY_ZERO=1; A=0, B=0 -> R=7FC00000, no flags.
REQ-035 A=7F000000, B=3E800000 -> R=7F800000, OVERFLOW=1; A=00800000, B=40000000 -> R=00000000, UNDERFLOW=1.
REQ-036 Handshake and reset sequence:
  - START re-pulsed at cycle 10 of an operation -> ignored, single DONE at 27 with the original result;
  - RST_N low at cycle 15 -> no DONE, outputs 0;
  - new START after release -> correct result 27 cycles later.
REQ-037 Back-to-back: START held high continuously -> DONE every 28 cycles, each R matching the operands present on its accept edge.
